id_hazard_ctrl: RTL and testbench
=================================

Name: id_hazard_ctrl

Overview:
- Pipeline scheduler for the decode stage, where branches are resolved.
- Keeps its own 3-entry in-flight destination scoreboard covering the EX, MEM and WB slots.
- Each cycle it produces the ID-stage forwarding selects, the IF/ID and ID stall, the ID/EX bubble and the IF/ID flush.
- Also keeps saturating performance counters for stalls, branches and mispredicts.

Parameters:
- CNT_W, 32, width of each performance counter.
- XREG_W, 5, width of register index fields.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  reset.
- i_hold  in  1  global pipeline freeze (e.g. memory busy); nothing advances.
- i_id_valid  in  1  ID holds a real instruction (not a bubble).
- i_id_rs1, i_id_rs2  in  XREG_W  source indices of the ID instruction.
- i_id_use_rs1, i_id_use_rs2  in  1  ID instruction reads rs1 / rs2.
- i_id_is_branch, i_id_is_jump  in  1  conditional branch; JAL/JALR.
- i_id_rd  in  XREG_W  destination of the ID instruction.
- i_id_wb_en  in  1  ID instruction writes rd.
- i_id_mem_read  in  1  ID instruction is a load.
- i_id_redirect_valid  in  1  ID redirect request (already suppressed by ID while stalled).
- i_id_mispred  in  1  ID conditional-branch mispredict flag.
- i_cnt_clr  in  1  synchronous clear of all counters.
- o_stall  out  1  hold PC and IF/ID, freeze ID.
- o_bubble_idex  out  1  load a bubble into ID/EX.
- o_flush_ifid  out  1  squash IF/ID on the next edge.
- o_fwd_a_sel, o_fwd_b_sel  out  2  00 = regfile, 01 = WB data, 10 = EX/MEM ALU result.
- o_cnt_stall, o_cnt_branch, o_cnt_mispred  out  CNT_W  performance counters.

Behaviour:
- Reset and clock:
  - Single clock i_clk.
  - Reset i_reset is synchronous, active-high.
  - On reset: all scoreboard entries invalid and all counters 0. With the scoreboard empty, o_stall = 0, o_bubble_idex = 0, o_fwd_* = 00, and o_flush_ifid = i_id_redirect_valid.
- Scoreboard:
  - Three entries, SB_EX, SB_MEM and SB_WB, each {valid, rd, wb_en, mem_read}.
  - An entry "writes r" iff valid & wb_en & rd == r & r != 0. Register x0 never matches.
- Hazard and forward evaluation, combinational, per used source rs (a: rs1/use_rs1, b: rs2/use_rs2):
  - Branch or jump consumer:
    - SB_EX writes rs: stall.
    - Else SB_MEM writes rs and is a load: stall.
    - Else SB_MEM writes rs: fwd = 10.
    - Else SB_WB writes rs: fwd = 01.
    - Else: fwd = 00.
  - Other consumers:
    - SB_EX writes rs and is a load: stall (load-use).
    - Else SB_MEM writes rs and is not a load: fwd = 10.
    - Else SB_WB writes rs: fwd = 01.
    - Else: fwd = 00.
  - An unused source always gets fwd = 00 and never stalls.
  - MEM has priority over WB for forwarding.
- Output equations:
  - hazard = i_id_valid & (stall condition on a or b).
  - o_stall = hazard | i_hold.
  - o_bubble_idex = hazard & !i_hold.
  - o_flush_ifid = i_id_redirect_valid & !o_stall.
- Scoreboard update at each posedge when !i_reset:
  - i_hold = 1: no shift; all entries keep their values.
  - Otherwise: SB_WB <= SB_MEM and SB_MEM <= SB_EX.
  - SB_EX <= {i_id_valid & !hazard, i_id_rd, i_id_wb_en, i_id_mem_read}. A bubble enters as an invalid entry.
- Counters at each posedge:
  - i_reset or i_cnt_clr: all counters cleared. Clear wins over increment in the same cycle.
  - Otherwise, each counter saturates at all-ones and never wraps.
  - o_cnt_stall += 1 when o_bubble_idex.
  - o_cnt_branch += 1 when i_id_valid & i_id_is_branch & !o_stall.
  - o_cnt_mispred += 1 when i_id_mispred & !o_stall.
- Latency: outputs are combinational from the current scoreboard and ID inputs; scoreboard state lags by one cycle per stage.
- Multi-cycle stalls:
  - Load followed by a dependent branch stalls exactly 2 cycles: first for SB_EX load, then for SB_MEM load. It then forwards 01 from WB.
  - ALU op followed by a dependent branch stalls 1 cycle, then forwards 10.
- Simultaneous events:
  - Redirect and hazard in the same cycle: the stall wins and no flush occurs (ID suppresses its redirect while stalled).
  - i_hold with a hazard: no bubble is inserted; the hazard is re-evaluated after the hold releases.
- Reset mid-stall clears the scoreboard, so the next cycle has no stall.

Test Plan:
- Reset released, i_id_valid = 1 ADD x3,x1,x2 with empty scoreboard -> o_stall = 0, o_fwd_a_sel = o_fwd_b_sel = 00, all counters 0.
- LW x5 accepted, next cycle BEQ x5,x0 in ID:
  - Expected: o_stall = 1 for 2 consecutive cycles with o_bubble_idex = 1.
  - Expected: third cycle o_stall = 0, o_fwd_a_sel = 01.
  - Expected: o_cnt_stall = 2, o_cnt_branch = 1.
- ADDI x7 accepted, then BNE x7,x7:
  - Expected: 1-cycle stall, then o_fwd_a_sel = o_fwd_b_sel = 10, and o_cnt_stall = 1.
- LW x4 accepted, then ADD x6,x4,x0: 1-cycle stall. ADDI x0,x0,1 followed by BEQ x0,x0: never stalls, fwd = 00.
- JAL with i_id_redirect_valid = 1, no hazard:
  - Expected: o_flush_ifid = 1 that cycle.
  - Expected: the same stimulus with a pending SB_EX hazard on a JALR rs1 gives o_flush_ifid = 0 and o_stall = 1.
- Counter saturation and hold:
  - Preload via CNT_W = 4 build and 20 mispredicts -> o_cnt_mispred = 15.
  - i_cnt_clr -> 0 next cycle.
  - i_hold = 1 for 3 cycles -> scoreboard unchanged and o_stall = 1 throughout.

Source files
------------

// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard and scheduling control: in-flight destination scoreboard,
// ID forwarding selects, stall/bubble/flush generation and saturating perf counters.
module id_hazard_ctrl #(
  parameter int CNT_W  = 32,
  parameter int XREG_W = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_hold,
  input  logic              i_id_valid,
  input  logic [XREG_W-1:0] i_id_rs1,
  input  logic [XREG_W-1:0] i_id_rs2,
  input  logic              i_id_use_rs1,
  input  logic              i_id_use_rs2,
  input  logic              i_id_is_branch,
  input  logic              i_id_is_jump,
  input  logic [XREG_W-1:0] i_id_rd,
  input  logic              i_id_wb_en,
  input  logic              i_id_mem_read,
  input  logic              i_id_redirect_valid,
  input  logic              i_id_mispred,
  input  logic              i_cnt_clr,
  output logic              o_stall,
  output logic              o_bubble_idex,
  output logic              o_flush_ifid,
  output logic [1:0]        o_fwd_a_sel,
  output logic [1:0]        o_fwd_b_sel,
  output logic [CNT_W-1:0]  o_cnt_stall,
  output logic [CNT_W-1:0]  o_cnt_branch,
  output logic [CNT_W-1:0]  o_cnt_mispred
);

  localparam logic [1:0]       FWD_RF  = 2'b00;
  localparam logic [1:0]       FWD_WB  = 2'b01;
  localparam logic [1:0]       FWD_MEM = 2'b10;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef struct packed {
    logic              valid;
    logic [XREG_W-1:0] rd;
    logic              wb_en;
    logic              mem_read;
  } sb_entry_t;

  sb_entry_t sb_ex, sb_mem, sb_wb;
  sb_entry_t sb_new;

  logic       stall_a, stall_b;
  logic [1:0] fwd_a, fwd_b;
  logic       hazard;
  logic       ctrl_consumer;

  function automatic logic writes(input sb_entry_t e, input logic [XREG_W-1:0] r);
    return e.valid & e.wb_en & (e.rd == r) & (r != '0);
  endfunction

  // Branches resolve in ID, so they cannot consume EX results and must wait on MEM loads.
  function automatic logic [2:0] eval_src(
    input logic              use_src,
    input logic [XREG_W-1:0] rs,
    input logic              ctrl,
    input sb_entry_t         ex,
    input sb_entry_t         mem,
    input sb_entry_t         wb
  );
    logic       st;
    logic [1:0] fw;
    st = 1'b0;
    fw = FWD_RF;
    if (use_src) begin
      if (ctrl) begin
        if (writes(ex, rs))                      st = 1'b1;
        else if (writes(mem, rs) && mem.mem_read) st = 1'b1;
        else if (writes(mem, rs))                fw = FWD_MEM;
        else if (writes(wb, rs))                 fw = FWD_WB;
      end else begin
        if (writes(ex, rs) && ex.mem_read)        st = 1'b1;
        else if (writes(mem, rs) && !mem.mem_read) fw = FWD_MEM;
        else if (writes(wb, rs))                  fw = FWD_WB;
      end
    end
    return {st, fw};
  endfunction

  always_comb begin
    ctrl_consumer      = i_id_is_branch | i_id_is_jump;
    {stall_a, fwd_a}   = eval_src(i_id_use_rs1, i_id_rs1, ctrl_consumer, sb_ex, sb_mem, sb_wb);
    {stall_b, fwd_b}   = eval_src(i_id_use_rs2, i_id_rs2, ctrl_consumer, sb_ex, sb_mem, sb_wb);
    hazard             = i_id_valid & (stall_a | stall_b);
    o_stall            = hazard | i_hold;
    o_bubble_idex      = hazard & ~i_hold;
    o_flush_ifid       = i_id_redirect_valid & ~o_stall;
    o_fwd_a_sel        = fwd_a;
    o_fwd_b_sel        = fwd_b;
    sb_new.valid       = i_id_valid & ~hazard;
    sb_new.rd          = i_id_rd;
    sb_new.wb_en       = i_id_wb_en;
    sb_new.mem_read    = i_id_mem_read;
  end

  // A hold freezes the whole scoreboard so hazards are re-evaluated once it releases.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sb_ex  <= '0;
      sb_mem <= '0;
      sb_wb  <= '0;
    end else if (!i_hold) begin
      sb_wb  <= sb_mem;
      sb_mem <= sb_ex;
      sb_ex  <= sb_new;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_cnt_clr) begin
      o_cnt_stall   <= '0;
      o_cnt_branch  <= '0;
      o_cnt_mispred <= '0;
    end else begin
      if (o_bubble_idex && (o_cnt_stall != '1))
        o_cnt_stall <= o_cnt_stall + CNT_ONE;
      if (i_id_valid && i_id_is_branch && !o_stall && (o_cnt_branch != '1))
        o_cnt_branch <= o_cnt_branch + CNT_ONE;
      if (i_id_mispred && !o_stall && (o_cnt_mispred != '1))
        o_cnt_mispred <= o_cnt_mispred + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Self-checking bench for id_hazard_ctrl: directed vector table, hand sequences,
// and randomized traffic against a queue-based reference of the in-flight pipeline.
module tb_id_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset, hold, id_valid, use1, use2, is_br, is_jmp, wb, ld, redir, misp, clr;
  logic [4:0] rs1, rs2, rd;
  logic       stall, bubble, flush;
  logic [1:0] fwd_a, fwd_b;
  logic [31:0] cnt_stall, cnt_branch, cnt_mispred;
  logic       s_stall, s_bubble, s_flush;
  logic [1:0] s_fwd_a, s_fwd_b;
  logic [3:0] s_cnt_stall, s_cnt_branch, s_cnt_mispred;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_hazard_ctrl #(.CNT_W(32), .XREG_W(5)) dut (
    .i_clk(clk), .i_reset(reset), .i_hold(hold), .i_id_valid(id_valid),
    .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_use_rs1(use1), .i_id_use_rs2(use2),
    .i_id_is_branch(is_br), .i_id_is_jump(is_jmp), .i_id_rd(rd), .i_id_wb_en(wb),
    .i_id_mem_read(ld), .i_id_redirect_valid(redir), .i_id_mispred(misp), .i_cnt_clr(clr),
    .o_stall(stall), .o_bubble_idex(bubble), .o_flush_ifid(flush),
    .o_fwd_a_sel(fwd_a), .o_fwd_b_sel(fwd_b),
    .o_cnt_stall(cnt_stall), .o_cnt_branch(cnt_branch), .o_cnt_mispred(cnt_mispred)
  );

  id_hazard_ctrl #(.CNT_W(4), .XREG_W(5)) dut_small (
    .i_clk(clk), .i_reset(reset), .i_hold(hold), .i_id_valid(id_valid),
    .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_use_rs1(use1), .i_id_use_rs2(use2),
    .i_id_is_branch(is_br), .i_id_is_jump(is_jmp), .i_id_rd(rd), .i_id_wb_en(wb),
    .i_id_mem_read(ld), .i_id_redirect_valid(redir), .i_id_mispred(misp), .i_cnt_clr(clr),
    .o_stall(s_stall), .o_bubble_idex(s_bubble), .o_flush_ifid(s_flush),
    .o_fwd_a_sel(s_fwd_a), .o_fwd_b_sel(s_fwd_b),
    .o_cnt_stall(s_cnt_stall), .o_cnt_branch(s_cnt_branch), .o_cnt_mispred(s_cnt_mispred)
  );

  typedef struct {
    bit       reset, hold, valid, use1, use2, br, jmp, wb, ld, redir, misp, clr;
    bit [4:0] rs1, rs2, rd;
    bit       e_stall, e_bub, e_flush;
    bit [1:0] e_fa, e_fb;
    int       e_cst, e_cbr;
  } vec_t;

  typedef struct {
    bit       valid;
    bit [4:0] rd;
    bit       wb;
    bit       ld;
  } ent_t;

  // Reference pipeline: index 0 is the instruction one stage past ID, 1 two stages, 2 three.
  ent_t   pipe[$];
  longint m_cst, m_cbr, m_cmis;
  int     m_scst, m_scbr, m_scmis;

  function automatic vec_t vec(input bit hold_i, valid_i, input bit [4:0] rs1_i, input bit u1,
                               input bit [4:0] rs2_i, input bit u2, input bit br_i, jmp_i,
                               input bit [4:0] rd_i, input bit wb_i, ld_i, redir_i, misp_i,
                               input bit es, eb, ef, input bit [1:0] fa, fb, input int cst, cbr);
    vec_t v;
    v = '{default: 0};
    v.hold = hold_i; v.valid = valid_i; v.rs1 = rs1_i; v.use1 = u1; v.rs2 = rs2_i; v.use2 = u2;
    v.br = br_i; v.jmp = jmp_i; v.rd = rd_i; v.wb = wb_i; v.ld = ld_i; v.redir = redir_i;
    v.misp = misp_i; v.e_stall = es; v.e_bub = eb; v.e_flush = ef; v.e_fa = fa; v.e_fb = fb;
    v.e_cst = cst; v.e_cbr = cbr;
    return v;
  endfunction

  function automatic bit produces(int s, bit [4:0] r);
    return pipe[s].valid && pipe[s].wb && pipe[s].rd == r && r != 0;
  endfunction

  function automatic void ref_src(input bit used, input bit [4:0] r, input bit ctrl,
                                  output bit st, output bit [1:0] fw);
    st = 0;
    fw = 2'b00;
    if (!used) return;
    if (ctrl) begin
      if (produces(0, r))                   st = 1;
      else if (produces(1, r) && pipe[1].ld) st = 1;
      else if (produces(1, r))              fw = 2'b10;
      else if (produces(2, r))              fw = 2'b01;
    end else begin
      if (produces(0, r) && pipe[0].ld)      st = 1;
      else if (produces(1, r) && !pipe[1].ld) fw = 2'b10;
      else if (produces(2, r))              fw = 2'b01;
    end
  endfunction

  task automatic model_reset();
    ent_t e;
    e = '{default: 0};
    pipe = {};
    repeat (3) pipe.push_back(e);
    m_cst = 0; m_cbr = 0; m_cmis = 0;
    m_scst = 0; m_scbr = 0; m_scmis = 0;
  endtask

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input bit use_table);
    bit sa, sb, hz, st, bub, fl;
    bit [1:0] fa, fb;
    ent_t e;
    reset = v.reset; hold = v.hold; id_valid = v.valid; rs1 = v.rs1; rs2 = v.rs2;
    use1 = v.use1; use2 = v.use2; is_br = v.br; is_jmp = v.jmp; rd = v.rd; wb = v.wb;
    ld = v.ld; redir = v.redir; misp = v.misp; clr = v.clr;
    @(negedge clk);
    ref_src(v.use1, v.rs1, v.br | v.jmp, sa, fa);
    ref_src(v.use2, v.rs2, v.br | v.jmp, sb, fb);
    hz  = v.valid && (sa || sb);
    st  = hz || v.hold;
    bub = hz && !v.hold;
    fl  = v.redir && !st;
    checkOutput("stall", stall, st);
    checkOutput("bubble", bubble, bub);
    checkOutput("flush", flush, fl);
    if (!sa) checkOutput("fwd_a", fwd_a, fa);
    if (!sb) checkOutput("fwd_b", fwd_b, fb);
    checkOutput("cnt_stall", cnt_stall, m_cst);
    checkOutput("cnt_branch", cnt_branch, m_cbr);
    checkOutput("cnt_mispred", cnt_mispred, m_cmis);
    checkOutput("small_cnt_stall", s_cnt_stall, m_scst);
    checkOutput("small_cnt_branch", s_cnt_branch, m_scbr);
    checkOutput("small_cnt_mispred", s_cnt_mispred, m_scmis);
    if (use_table) begin
      checkOutput("tab_stall", stall, v.e_stall);
      checkOutput("tab_bubble", bubble, v.e_bub);
      checkOutput("tab_flush", flush, v.e_flush);
      if (!v.e_stall) begin
        checkOutput("tab_fwd_a", fwd_a, v.e_fa);
        checkOutput("tab_fwd_b", fwd_b, v.e_fb);
      end
      checkOutput("tab_cnt_stall", cnt_stall, v.e_cst);
      checkOutput("tab_cnt_branch", cnt_branch, v.e_cbr);
    end
    if (v.reset) begin
      model_reset();
    end else begin
      if (!v.hold) begin
        e.valid = v.valid && !hz; e.rd = v.rd; e.wb = v.wb; e.ld = v.ld;
        pipe.push_front(e);
        void'(pipe.pop_back());
      end
      if (v.clr) begin
        m_cst = 0; m_cbr = 0; m_cmis = 0; m_scst = 0; m_scbr = 0; m_scmis = 0;
      end else begin
        if (bub) begin
          if (m_cst < 64'hFFFF_FFFF) m_cst++;
          if (m_scst < 15) m_scst++;
        end
        if (v.valid && v.br && !st) begin
          if (m_cbr < 64'hFFFF_FFFF) m_cbr++;
          if (m_scbr < 15) m_scbr++;
        end
        if (v.misp && !st) begin
          if (m_cmis < 64'hFFFF_FFFF) m_cmis++;
          if (m_scmis < 15) m_scmis++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    vec_t v;
    v = '{default: 0};
    v.reset = 1;
    applyStimulus(v, 0);
  endtask

  vec_t table_v[$];
  vec_t v;

  initial begin
    reset = 1; hold = 0; id_valid = 0; rs1 = 0; rs2 = 0; use1 = 0; use2 = 0; is_br = 0;
    is_jmp = 0; rd = 0; wb = 0; ld = 0; redir = 0; misp = 0; clr = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // hold valid rs1 u1 rs2 u2 br jmp rd wb ld redir misp | stall bub flush fa fb cst cbr
    table_v.push_back(vec(0,1, 1,1, 2,1, 0,0, 3,1,0, 0,0,  0,0,0, 2'b00,2'b00, 0,0));
    table_v.push_back(vec(0,1, 0,1, 0,0, 0,0, 5,1,1, 0,0,  0,0,0, 2'b00,2'b00, 0,0));
    table_v.push_back(vec(0,1, 5,1, 0,1, 1,0, 0,0,0, 0,0,  1,1,0, 2'b00,2'b00, 0,0));
    table_v.push_back(vec(0,1, 5,1, 0,1, 1,0, 0,0,0, 0,0,  1,1,0, 2'b00,2'b00, 1,0));
    table_v.push_back(vec(0,1, 5,1, 0,1, 1,0, 0,0,0, 0,0,  0,0,0, 2'b01,2'b00, 2,0));
    table_v.push_back(vec(0,1, 0,1, 0,0, 0,0, 7,1,0, 0,0,  0,0,0, 2'b00,2'b00, 2,1));
    table_v.push_back(vec(0,1, 7,1, 7,1, 1,0, 0,0,0, 0,0,  1,1,0, 2'b00,2'b00, 2,1));
    table_v.push_back(vec(0,1, 7,1, 7,1, 1,0, 0,0,0, 0,0,  0,0,0, 2'b10,2'b10, 3,1));
    table_v.push_back(vec(0,1, 0,1, 0,0, 0,0, 4,1,1, 0,0,  0,0,0, 2'b00,2'b00, 3,2));
    table_v.push_back(vec(0,1, 4,1, 0,1, 0,0, 6,1,0, 0,0,  1,1,0, 2'b00,2'b00, 3,2));
    table_v.push_back(vec(0,1, 4,1, 0,1, 0,0, 6,1,0, 0,0,  0,0,0, 2'b00,2'b00, 4,2));
    table_v.push_back(vec(0,1, 0,1, 0,0, 0,0, 0,1,0, 0,0,  0,0,0, 2'b00,2'b00, 4,2));
    table_v.push_back(vec(0,1, 0,1, 0,1, 1,0, 0,0,0, 0,0,  0,0,0, 2'b00,2'b00, 4,2));
    table_v.push_back(vec(0,1, 0,0, 0,0, 0,1, 1,1,0, 1,0,  0,0,1, 2'b00,2'b00, 4,3));
    table_v.push_back(vec(0,1, 1,1, 0,0, 0,1, 0,0,0, 1,0,  1,1,0, 2'b00,2'b00, 4,3));
    table_v.push_back(vec(0,1, 1,1, 0,0, 0,1, 0,0,0, 1,0,  0,0,1, 2'b10,2'b00, 5,3));
    table_v.push_back(vec(0,1, 0,0, 0,0, 1,0, 0,0,0, 0,1,  0,0,0, 2'b00,2'b00, 5,3));
    table_v.push_back(vec(0,0, 0,0, 0,0, 0,0, 0,0,0, 0,0,  0,0,0, 2'b00,2'b00, 5,4));
    foreach (table_v[i]) applyStimulus(table_v[i], 1);
    checkOutput("seq_cnt_mispred", cnt_mispred, 1);

    // Hold over a pending load-use: no bubble while frozen, hazard still there after release.
    pulse_reset();
    applyStimulus(vec(0,1, 0,1, 0,0, 0,0, 9,1,1, 0,0,  0,0,0, 2'b00,2'b00, 0,0), 1);
    repeat (3)
      applyStimulus(vec(1,1, 9,1, 0,0, 0,0, 10,1,0, 0,0, 1,0,0, 2'b00,2'b00, 0,0), 1);
    applyStimulus(vec(0,1, 9,1, 0,0, 0,0, 10,1,0, 0,0, 1,1,0, 2'b00,2'b00, 0,0), 1);
    applyStimulus(vec(0,1, 9,1, 0,0, 0,0, 10,1,0, 0,0, 0,0,0, 2'b00,2'b00, 1,0), 1);

    // Reset in the middle of a stall empties the scoreboard.
    pulse_reset();
    applyStimulus(vec(0,1, 0,1, 0,0, 0,0, 9,1,1, 0,0,  0,0,0, 2'b00,2'b00, 0,0), 1);
    applyStimulus(vec(0,1, 9,1, 0,0, 1,0, 0,0,0, 0,0,  1,1,0, 2'b00,2'b00, 0,0), 1);
    v = vec(0,1, 9,1, 0,0, 1,0, 0,0,0, 0,0, 1,1,0, 2'b00,2'b00, 1,0);
    v.reset = 1;
    applyStimulus(v, 0);
    applyStimulus(vec(0,1, 9,1, 0,0, 1,0, 0,0,0, 0,0,  0,0,0, 2'b00,2'b00, 0,0), 1);

    // Saturation on the 4-bit instance, then synchronous clear.
    pulse_reset();
    repeat (20) applyStimulus(vec(0,0, 0,0, 0,0, 0,0, 0,0,0, 0,1, 0,0,0, 2'b00,2'b00, 0,0), 1);
    checkOutput("sat_small_mispred", s_cnt_mispred, 15);
    checkOutput("sat_big_mispred", cnt_mispred, 20);
    v = vec(0,0, 0,0, 0,0, 0,0, 0,0,0, 0,1, 0,0,0, 2'b00,2'b00, 0,0);
    v.clr = 1;
    applyStimulus(v, 0);
    checkOutput("clr_small_mispred", s_cnt_mispred, 0);
    checkOutput("clr_big_mispred", cnt_mispred, 0);

    // Random traffic over a small register set to provoke frequent dependencies.
    for (int n = 0; n < 600; n++) begin
      v = '{default: 0};
      v.reset = ($urandom_range(63) == 0);
      v.clr   = ($urandom_range(47) == 0);
      v.hold  = ($urandom_range(7) == 0);
      v.valid = ($urandom_range(7) != 0);
      v.rs1   = 5'($urandom_range(3));
      v.rs2   = 5'($urandom_range(3));
      v.rd    = 5'($urandom_range(3));
      v.use1  = 1'($urandom);
      v.use2  = 1'($urandom);
      v.br    = ($urandom_range(3) == 0);
      v.jmp   = !v.br && ($urandom_range(7) == 0);
      v.wb    = 1'($urandom);
      v.ld    = v.wb && ($urandom_range(2) == 0);
      v.redir = ($urandom_range(3) == 0);
      v.misp  = v.br && ($urandom_range(2) == 0);
      applyStimulus(v, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
